// File: rtl/fifo_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter_if
// Bundle of the requester handshake and FIFO write-side signals that
// fifo_write_arbiter arbitrates between.
//
// Signals:
//   enable      arbiter enable (no new grant while low)
//   req_valid   per-requester beat valid, bit i = requester i
//   req_data    per-requester beat, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   per-requester accept strobe
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write strobe
//   fifo_din    FIFO write data
//   grant_id    index of the current grantee (meaningful while busy)
//   busy        high while a requester holds the grant
//
// Modports:
//   master  arbiter side (drives ready, FIFO write, status)
//   slave   requesters + FIFO side
// -----------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int GW = $clog2(NUM_REQ);

   logic                          enable;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic [GW-1:0]                 grant_id;
   logic                          busy;

   modport master (
      input  enable, req_valid, req_data, fifo_full,
      output req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );

   modport slave (
      output enable, req_valid, req_data, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one synchronous FIFO write port between
// NUM_REQ valid/ready requesters. A grantee keeps the port for up to
// MAX_BURST beats, or until it drops valid, then the grant rotates to the
// nearest requester above it. The FIFO full flag gates every write, so no
// beat is ever dropped.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fifo_write_arbiter_if.master (handshake, FIFO write, status)
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fifo_write_arbiter_if.master     bus
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]      r_state;
   logic [GW-1:0]   r_rr_ptr;
   logic [GW-1:0]   r_grant_id;
   logic [CW-1:0]   r_burst_cnt;

   logic                  w_busy;
   logic                  w_active;
   logic                  w_cur_valid;
   logic                  w_transfer;
   logic                  w_burst_last;
   logic                  w_release;
   logic                  w_found;
   logic [GW-1:0]         w_next_ptr;
   logic [GW-1:0]         w_scan_start;
   logic [GW-1:0]         w_winner;
   logic [DATA_WIDTH-1:0] w_req_beat [NUM_REQ];

   // Unpack the flat data bus so the grantee's beat is a simple array select.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_beat[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   function automatic int wrap_idx(input int base, input int ofs);
      int sum;
      sum = base + ofs;
      return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
   endfunction

   assign w_busy       = (r_state == ST_GRANT);
   // Outputs are masked during reset so a beat offered in the reset cycle
   // is never accepted, even if the state register still reads GRANT.
   assign w_active     = rst_n && w_busy;
   assign w_cur_valid  = bus.req_valid[r_grant_id];
   assign w_transfer   = w_active && w_cur_valid && !bus.fifo_full;
   assign w_burst_last = (r_burst_cnt == CW'(MAX_BURST - 1));
   assign w_release    = w_busy && ((w_transfer && w_burst_last) || !w_cur_valid);
   assign w_next_ptr   = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

   // In GRANT the scan starts just above the grantee, which puts the
   // grantee's own current valid at lowest priority for the back-to-back
   // re-arbitration. In IDLE it starts from the round-robin pointer.
   assign w_scan_start = w_busy ? w_next_ptr : r_rr_ptr;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && bus.req_valid[GW'(wrap_idx(int'(w_scan_start), k))]) begin
            w_found  = 1'b1;
            w_winner = GW'(wrap_idx(int'(w_scan_start), k));
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (w_active && !bus.fifo_full) begin
         bus.req_ready[r_grant_id] = 1'b1;
      end
   end

   assign bus.fifo_wr_en = w_transfer;
   assign bus.fifo_din   = w_active ? w_req_beat[r_grant_id] : '0;
   assign bus.grant_id   = r_grant_id;
   assign bus.busy       = w_busy;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.enable && w_found) begin
                  r_grant_id  <= w_winner;
                  r_burst_cnt <= '0;
                  r_state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_transfer) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
               if (w_release) begin
                  r_rr_ptr <= w_next_ptr;
                  if (bus.enable && w_found) begin
                     r_grant_id  <= w_winner;
                     r_burst_cnt <= '0;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ independent requesters.
- Each requester offers a data stream with a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats and drives the FIFO's wr_en/din.
- It honours the FIFO's full flag so that no beat is ever dropped.
- It sits directly in front of the FIFO write side. The FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must match the FIFO's data width.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..255).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  when low, no new grant is issued; a grant already in progress runs to release.
- req_valid  input  NUM_REQ  bit i high = requester i presents a beat.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i beat in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  bit i high = beat of requester i accepted this cycle when valid.
- fifo_full  input  1  full flag from the FIFO.
- fifo_wr_en  output  1  write strobe to the FIFO.
- fifo_din  output  DATA_WIDTH  write data to the FIFO.
- grant_id  output  clog2(NUM_REQ)  index of the current grantee; valid while busy.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (rst_n low at a clock edge, any state, including mid-burst):
  - state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0, busy=0.
  - req_ready=0, fifo_wr_en=0, fifo_din=0.
  - A beat offered in the reset cycle is not accepted.
- States: IDLE, GRANT. State, rr_ptr, grant_id and burst_cnt are registered.
- Arbitration function:
  - Scan req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit wins. The winner is registered into grant_id.
- IDLE:
  - If enable and any req_valid: grant_id <= winner, burst_cnt <= 0, go GRANT.
  - Arbitration latency is one cycle: no beat transfers in IDLE.
- GRANT, per cycle, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - fifo_wr_en = transfer, combinational in the same cycle. fifo_din = req_data[g] while busy, else 0.
  - On transfer: burst_cnt <= burst_cnt+1.
  - fifo_full high: no transfer, burst_cnt holds, grant holds. There is no stall timeout.
- Release, evaluated each GRANT cycle:
  - Release occurs when (transfer && burst_cnt == MAX_BURST-1) or !req_valid[g].
  - A cycle with req_valid[g] low releases with no transfer.
- On release:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Re-arbitrate in the same cycle, scanning from (g+1) mod NUM_REQ using current req_valid.
  - Requester g's current-cycle valid participates at lowest priority.
  - If enable and a winner exists: stay in GRANT, grant_id <= winner, burst_cnt <= 0. This gives back-to-back grants with no bubble.
  - Otherwise go IDLE.
- enable low in GRANT: the burst continues. At release the block goes IDLE regardless of pending requests.
- Simultaneous events:
  - Release by burst limit while others are requesting: the next grantee is the nearest requester above g.
  - With only g requesting, g is re-granted immediately with a fresh burst_cnt.
- Wrap-around: rr_ptr and the scan index wrap from NUM_REQ-1 to 0. burst_cnt width is clog2(MAX_BURST+1).
- Overflow safety:
  - fifo_wr_en is never asserted while fifo_full is high.
  - The FIFO's full flag asserts on the cycle after the write that fills it, so no beat is lost or duplicated.
- Ordering: beats from one requester enter the FIFO in their offered order. Beats are never reordered within a requester.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req_valid=0 -> req_ready=0, fifo_wr_en=0, busy=0, grant_id=0 throughout.
- Single requester:
  - Stimulus: req_valid=4'b0010 continuously, data 0x10,0x11,0x12,...; MAX_BURST=4; FIFO never full.
  - Response: busy rises 1 cycle after valid; fifo_din carries 0x10..0x13 on 4 consecutive cycles; then g=1 is re-granted with no bubble and 0x14.. follows.
- Round-robin:
  - Stimulus: all four valid continuously with data 0xA0+i.
  - Response: grant order 0,1,2,3,0; each grant writes exactly 4 beats; 16 writes complete in 17 cycles from the first valid.
- Early release:
  - Stimulus: req 2 valid for 2 beats then low; req 3 valid.
  - Response: 2 beats from req 2 are written; a no-transfer release cycle follows; grant_id=3 on the next cycle; rr_ptr=3.
- Full stall:
  - Stimulus: fifo_full=1 for 5 cycles mid-burst of req 0 after 2 beats.
  - Response: req_ready=0 and fifo_wr_en=0 for those 5 cycles; grant stays 0; after full drops, exactly 2 more beats are written before rotation.
- Reset mid-burst and enable:
  - Stimulus: rst_n=0 during beat 2 of a grant.
  - Response: the next cycle has busy=0 and fifo_wr_en=0, and after reset arbitration restarts from requester 0.
  - Stimulus: enable=0 during a grant.
  - Response: the grant completes its burst, then busy=0 with requests still pending.
